// File: rtl/e203_ifu_bjp_prdt.sv
// Static branch/jump predictor for the IFU mini-decode path.
// Resolves JALR base-register hazards before borrowing the shared rs1 read port.
module e203_ifu_bjp_prdt #(
    parameter int unsigned XLEN    = 32,
    parameter int unsigned RFIDX_W = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [XLEN-1:0]    in_pc,
    input  logic               dec_rv32,
    input  logic               dec_bjp,
    input  logic               dec_jal,
    input  logic               dec_jalr,
    input  logic               dec_bxx,
    input  logic [RFIDX_W-1:0] dec_jalr_rs1idx,
    input  logic [XLEN-1:0]    dec_bjp_imm,
    input  logic               oitf_empty,
    input  logic               ir_valid,
    input  logic               ir_rdwen,
    input  logic [RFIDX_W-1:0] ir_rdidx,
    input  logic               ir_rs1en,
    input  logic [XLEN-1:0]    rf_x1,
    output logic               bpu2rf_rs1_ena,
    input  logic [XLEN-1:0]    rf2bpu_rs1,
    input  logic               flush,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               prdt_taken,
    output logic [XLEN-1:0]    prdt_op1,
    output logic [XLEN-1:0]    prdt_op2,
    output logic [XLEN-1:0]    prdt_pc
);

    typedef enum logic [2:0] {
        IDLE,
        WAIT_DEP,
        RF_REQ,
        RF_RSP,
        OUT
    } state_e;

    state_e state, state_nxt;

    logic [RFIDX_W-1:0] rs1idx_q;
    logic               taken_q;
    logic [XLEN-1:0]    op1_q;
    logic [XLEN-1:0]    op2_q;

    logic               dec_is_jalr;
    logic               dec_rs1_x0;
    logic               dec_rs1_x1;
    logic [XLEN-1:0]    seq_step;
    logic               dec_taken;
    logic [XLEN-1:0]    dec_op1;
    logic [XLEN-1:0]    dec_op2;

    logic [RFIDX_W-1:0] cur_rs1;
    logic               dep;
    logic               rs1_is_x1_q;
    logic               accept;
    logic               rf_ena;
    logic               sample_x1;

    // Prediction for the instruction presented on the decode bus.
    always_comb begin
        dec_is_jalr = dec_bjp & ~dec_jal & dec_jalr;
        dec_rs1_x0  = (dec_jalr_rs1idx == '0);
        dec_rs1_x1  = (dec_jalr_rs1idx == RFIDX_W'(1));
        seq_step    = dec_rv32 ? XLEN'(4) : XLEN'(2);
        dec_taken   = 1'b0;
        dec_op1     = in_pc;
        dec_op2     = seq_step;
        if (dec_bjp) begin
            if (dec_jal) begin
                dec_taken = 1'b1;
                dec_op2   = dec_bjp_imm;
            end else if (dec_jalr) begin
                dec_taken = 1'b1;
                dec_op2   = dec_bjp_imm;
                dec_op1   = dec_rs1_x1 ? rf_x1 : '0;
            end else if (dec_bxx) begin
                dec_taken = dec_bjp_imm[XLEN-1];
                if (dec_bjp_imm[XLEN-1]) begin
                    dec_op2 = dec_bjp_imm;
                end
            end
        end
    end

    // In IDLE the hazard check looks at the incoming index, afterwards at the latched one.
    always_comb begin
        cur_rs1     = (state == IDLE) ? dec_jalr_rs1idx : rs1idx_q;
        dep         = ~oitf_empty | (ir_valid & ir_rdwen & (ir_rdidx == cur_rs1));
        rs1_is_x1_q = (rs1idx_q == RFIDX_W'(1));
        accept      = (state == IDLE) & in_valid;
        rf_ena      = (state == RF_REQ) & ~ir_rs1en & ~flush & ~rst;
        sample_x1   = (state == WAIT_DEP) & ~dep & rs1_is_x1_q;
    end

    always_ff @(posedge clk) begin
        if (rst | flush) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    if (~dec_is_jalr | dec_rs1_x0) begin
                        state_nxt = OUT;
                    end else if (dep) begin
                        state_nxt = WAIT_DEP;
                    end else begin
                        state_nxt = dec_rs1_x1 ? OUT : RF_REQ;
                    end
                end
            end
            WAIT_DEP: begin
                if (~dep) begin
                    state_nxt = rs1_is_x1_q ? OUT : RF_REQ;
                end
            end
            RF_REQ: begin
                if (rf_ena) begin
                    state_nxt = RF_RSP;
                end else if (dep) begin
                    state_nxt = WAIT_DEP;
                end
            end
            RF_RSP:  state_nxt = OUT;
            OUT: begin
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Operand 1 may be overwritten after acceptance once the base register is readable.
    always_ff @(posedge clk) begin
        if (rst | flush) begin
            rs1idx_q <= '0;
            taken_q  <= 1'b0;
            op1_q    <= '0;
            op2_q    <= '0;
        end else begin
            if (accept) begin
                rs1idx_q <= dec_jalr_rs1idx;
                taken_q  <= dec_taken;
                op1_q    <= dec_op1;
                op2_q    <= dec_op2;
            end
            if (sample_x1) begin
                op1_q <= rf_x1;
            end
            if (state == RF_RSP) begin
                op1_q <= rf2bpu_rs1;
            end
        end
    end

    always_comb begin
        in_ready       = (state == IDLE);
        out_valid      = (state == OUT);
        bpu2rf_rs1_ena = rf_ena;
        prdt_taken     = taken_q;
        prdt_op1       = op1_q;
        prdt_op2       = op2_q;
        prdt_pc        = op1_q + op2_q;
    end

endmodule

// File: tb/tb_e203_ifu_bjp_prdt.sv
// Bench for e203_ifu_bjp_prdt: directed scenarios with literal expectations,
// then randomized traffic checked every cycle against a transaction-level model.
module tb_e203_ifu_bjp_prdt;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_pc;
    logic        dec_rv32, dec_bjp, dec_jal, dec_jalr, dec_bxx;
    logic [4:0]  dec_jalr_rs1idx;
    logic [31:0] dec_bjp_imm;
    logic        oitf_empty, ir_valid, ir_rdwen, ir_rs1en;
    logic [4:0]  ir_rdidx;
    logic [31:0] rf_x1;
    logic        bpu2rf_rs1_ena;
    logic [31:0] rf2bpu_rs1;
    logic        flush;
    logic        out_valid, out_ready, prdt_taken;
    logic [31:0] prdt_op1, prdt_op2, prdt_pc;

    e203_ifu_bjp_prdt #(.XLEN(32), .RFIDX_W(5)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc),
        .dec_rv32(dec_rv32), .dec_bjp(dec_bjp), .dec_jal(dec_jal), .dec_jalr(dec_jalr),
        .dec_bxx(dec_bxx), .dec_jalr_rs1idx(dec_jalr_rs1idx), .dec_bjp_imm(dec_bjp_imm),
        .oitf_empty(oitf_empty), .ir_valid(ir_valid), .ir_rdwen(ir_rdwen),
        .ir_rdidx(ir_rdidx), .ir_rs1en(ir_rs1en), .rf_x1(rf_x1),
        .bpu2rf_rs1_ena(bpu2rf_rs1_ena), .rf2bpu_rs1(rf2bpu_rs1), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready), .prdt_taken(prdt_taken),
        .prdt_op1(prdt_op1), .prdt_op2(prdt_op2), .prdt_pc(prdt_pc)
    );

    always #5 clk = ~clk;

    typedef enum {M_IDLE, M_WAIT, M_REQ, M_RSP, M_OUT} mphase_e;

    mphase_e     phase = M_IDLE;
    bit          cleared = 1'b1;
    bit          e_taken;
    logic [31:0] e_op1, e_op2;
    int unsigned e_rs1;
    int unsigned n_pass = 0, n_total = 0, n_ena = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        else n_pass++;
    endtask

    function automatic bit dep_now(input int unsigned r);
        return !oitf_empty || (ir_valid && ir_rdwen && ir_rdidx == r[4:0]);
    endfunction

    task automatic check_cycle();
        if (rst) return;
        if (bpu2rf_rs1_ena === 1'b1) n_ena++;
        chk("in_ready", in_ready, phase == M_IDLE);
        chk("out_valid", out_valid, phase == M_OUT);
        chk("rs1_ena", bpu2rf_rs1_ena, phase == M_REQ && !ir_rs1en && !flush);
        if (phase == M_OUT) begin
            chk("taken", prdt_taken, e_taken);
            chk("op1", prdt_op1, e_op1);
            chk("op2", prdt_op2, e_op2);
            chk("pc", prdt_pc, 32'(e_op1 + e_op2));
        end else if (phase == M_IDLE && cleared) begin
            chk("cleared_pred", {prdt_taken, prdt_op1, prdt_op2, prdt_pc}, '0);
        end
    endtask

    // Advance the model across the coming clock edge using the inputs driven now.
    task automatic model_update();
        logic [31:0] step;
        if (rst || flush) begin
            phase = M_IDLE;
            cleared = 1'b1;
            return;
        end
        case (phase)
            M_IDLE: if (in_valid) begin
                cleared = 1'b0;
                step = dec_rv32 ? 32'd4 : 32'd2;
                e_rs1 = dec_jalr_rs1idx;
                e_op1 = in_pc;
                e_op2 = step;
                e_taken = 1'b0;
                phase = M_OUT;
                if (dec_bjp && dec_jal) begin
                    e_taken = 1'b1;
                    e_op2 = dec_bjp_imm;
                end else if (dec_bjp && dec_jalr) begin
                    e_taken = 1'b1;
                    e_op2 = dec_bjp_imm;
                    e_op1 = 32'd0;
                    if (e_rs1 != 0) begin
                        if (dep_now(e_rs1)) phase = M_WAIT;
                        else if (e_rs1 == 1) e_op1 = rf_x1;
                        else phase = M_REQ;
                    end
                end else if (dec_bjp && dec_bxx) begin
                    e_taken = $signed(dec_bjp_imm) < 0;
                    if (e_taken) e_op2 = dec_bjp_imm;
                end
            end
            M_WAIT: if (!dep_now(e_rs1)) begin
                if (e_rs1 == 1) begin
                    e_op1 = rf_x1;
                    phase = M_OUT;
                end else phase = M_REQ;
            end
            M_REQ: if (!ir_rs1en) phase = M_RSP;
                   else if (dep_now(e_rs1)) phase = M_WAIT;
            M_RSP: begin
                e_op1 = rf2bpu_rs1;
                phase = M_OUT;
            end
            M_OUT: if (out_ready) phase = M_IDLE;
            default: phase = M_IDLE;
        endcase
    endtask

    task automatic step();
        #1;
        check_cycle();
        model_update();
        @(negedge clk);
    endtask

    task automatic quiet();
        rst = 1'b0; in_valid = 1'b0; in_pc = '0; dec_rv32 = 1'b1; dec_bjp = 1'b0;
        dec_jal = 1'b0; dec_jalr = 1'b0; dec_bxx = 1'b0; dec_jalr_rs1idx = '0;
        dec_bjp_imm = '0; oitf_empty = 1'b1; ir_valid = 1'b0; ir_rdwen = 1'b0;
        ir_rdidx = '0; ir_rs1en = 1'b0; flush = 1'b0; out_ready = 1'b0;
        rf_x1 = '0; rf2bpu_rs1 = '0;
    endtask

    task automatic present(input logic [31:0] pc, input bit jal, input bit jalr, input bit bxx,
                           input logic [4:0] rs1, input logic [31:0] imm, input bit rv32);
        in_valid = 1'b1; in_pc = pc; dec_bjp = jal | jalr | bxx; dec_jal = jal;
        dec_jalr = jalr; dec_bxx = bxx; dec_jalr_rs1idx = rs1; dec_bjp_imm = imm;
        dec_rv32 = rv32;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned ena0;
        int unsigned k;
        quiet();
        rst = 1'b1;
        @(negedge clk);
        step(); step();
        rst = 1'b0;
        step();
        chk("reset_in_ready", in_ready, 1'b1);
        chk("reset_out_valid", out_valid, 1'b0);
        chk("reset_pc", prdt_pc, 32'h0);

        // JAL: latency 1, taken
        present(32'h8000_0000, 1, 0, 0, 5'd0, 32'h100, 1);
        step();
        in_valid = 1'b0;
        chk("jal_valid_lat1", out_valid, 1'b1);
        chk("jal_taken", prdt_taken, 1'b1);
        chk("jal_pc", prdt_pc, 32'h8000_0100);
        out_ready = 1'b1; step(); out_ready = 1'b0;

        // Bxx backward taken, forward not taken on a 16-bit instruction
        present(32'h200, 0, 0, 1, 5'd0, 32'hFFFF_FFF0, 1);
        step(); in_valid = 1'b0;
        chk("bxx_back_taken", prdt_taken, 1'b1);
        chk("bxx_back_pc", prdt_pc, 32'h1F0);
        out_ready = 1'b1; step(); out_ready = 1'b0;
        present(32'h200, 0, 0, 1, 5'd0, 32'h40, 0);
        step(); in_valid = 1'b0;
        chk("bxx_fwd_taken", prdt_taken, 1'b0);
        chk("bxx_fwd_pc", prdt_pc, 32'h202);
        out_ready = 1'b1; step(); out_ready = 1'b0;

        // JALR x1 held by an outstanding long-pipe write
        rf_x1 = 32'h1000; oitf_empty = 1'b0;
        present(32'h40, 0, 1, 0, 5'd1, 32'h4, 1);
        step(); in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("jalr_x1_wait", out_valid, 1'b0);
            if (i == 2) oitf_empty = 1'b1;
            step();
        end
        chk("jalr_x1_valid", out_valid, 1'b1);
        chk("jalr_x1_pc", prdt_pc, 32'h1004);
        out_ready = 1'b1; step(); out_ready = 1'b0;

        // JALR x5 yielding the read port to IR for two cycles
        ena0 = n_ena;
        present(32'h80, 0, 1, 0, 5'd5, 32'h0, 1);
        step(); in_valid = 1'b0;
        ir_rs1en = 1'b1; step(); step();
        ir_rs1en = 1'b0; step();
        rf2bpu_rs1 = 32'h3000; step(); rf2bpu_rs1 = 32'hDEAD_BEEF;
        chk("jalr_xn_ena_once", n_ena - ena0, 1);
        chk("jalr_xn_taken", prdt_taken, 1'b1);
        chk("jalr_xn_pc", prdt_pc, 32'h3000);
        out_ready = 1'b1; step(); out_ready = 1'b0;

        // Flush while the read response is due
        present(32'h90, 0, 1, 0, 5'd5, 32'h10, 1);
        step(); in_valid = 1'b0;
        step();
        flush = 1'b1; rf2bpu_rs1 = 32'h5555; step(); flush = 1'b0;
        chk("flush_idle", in_ready, 1'b1);
        chk("flush_pc_zero", prdt_pc, 32'h0);
        for (int i = 0; i < 3; i++) begin
            chk("flush_no_valid", out_valid, 1'b0);
            step();
        end
        present(32'h1000, 1, 0, 0, 5'd0, 32'h20, 1);
        step(); in_valid = 1'b0;
        chk("post_flush_pc", prdt_pc, 32'h1020);
        out_ready = 1'b1; step(); out_ready = 1'b0;

        // Consumer stall in OUT, then no acceptance in the exit cycle
        present(32'h3000, 1, 0, 0, 5'd0, 32'h8, 1);
        step();
        present(32'h7000, 0, 0, 1, 5'd0, 32'hFFFF_FF00, 0);
        for (int i = 0; i < 4; i++) begin
            chk("stall_pc", prdt_pc, 32'h3008);
            chk("stall_in_ready", in_ready, 1'b0);
            step();
        end
        out_ready = 1'b1; step(); out_ready = 1'b0;
        chk("exit_no_accept", out_valid, 1'b0);
        step(); in_valid = 1'b0;
        chk("second_pc", prdt_pc, 32'h6F00);
        out_ready = 1'b1; step(); out_ready = 1'b0;

        // Wrap-around of the predicted PC
        rf_x1 = 32'hFFFF_FFFC;
        present(32'h50, 0, 1, 0, 5'd1, 32'h8, 1);
        step(); in_valid = 1'b0;
        chk("wrap_pc", prdt_pc, 32'h4);
        out_ready = 1'b1; step();

        // Randomized traffic
        for (int c = 0; c < 4000; c++) begin
            k = $urandom % 4;
            rst = ($urandom % 700) == 0;
            flush = ($urandom % 40) == 0;
            in_valid = $urandom % 2;
            in_pc = $urandom;
            dec_rv32 = $urandom % 2;
            dec_bjp = (k != 0);
            dec_jal = (k == 1) || (k == 0 && ($urandom % 2) == 1);
            dec_jalr = (k == 2) || (k == 0 && ($urandom % 2) == 1);
            dec_bxx = (k == 3) || (k == 0 && ($urandom % 2) == 1);
            dec_jalr_rs1idx = 5'($urandom_range(0, 7));
            dec_bjp_imm = (($urandom % 2) == 1) ? $urandom : 32'($urandom_range(0, 255));
            oitf_empty = ($urandom % 4) != 0;
            ir_valid = $urandom % 2;
            ir_rdwen = $urandom % 2;
            ir_rdidx = 5'($urandom_range(0, 7));
            ir_rs1en = ($urandom % 3) == 0;
            rf_x1 = $urandom;
            rf2bpu_rs1 = $urandom;
            out_ready = $urandom % 2;
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/e203_ifu_bjp_prdt.md
Name: e203_ifu_bjp_prdt

Overview:
- Consumer side of the IFU mini-decode info bus. Takes the decoded branch/jump fields for one fetched instruction and produces a registered static prediction: taken flag, next-PC operands and the predicted next PC.
- Resolves JALR base-register hazards. It waits on outstanding writes, then borrows the shared regfile rs1 read port for one request/response.
- Sits between the mini-decoder and the IFU PC-generation logic.

Parameters:
XLEN, 32, data/PC width
RFIDX_W, 5, register index width

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
in_valid  in  1  decoded instruction valid
in_ready  out  1  block can accept an instruction
in_pc  in  XLEN  PC of the instruction
dec_rv32  in  1  1 = 32-bit instruction, 0 = 16-bit
dec_bjp  in  1  instruction is a branch or jump
dec_jal  in  1  JAL
dec_jalr  in  1  JALR
dec_bxx  in  1  conditional branch
dec_jalr_rs1idx  in  RFIDX_W  JALR base register index
dec_bjp_imm  in  XLEN  sign-extended branch/jump offset
oitf_empty  in  1  no long-pipe writeback outstanding
ir_valid  in  1  IR stage holds an instruction
ir_rdwen  in  1  IR instruction writes rd
ir_rdidx  in  RFIDX_W  IR destination index
ir_rs1en  in  1  IR is using the shared rs1 read port this cycle
rf_x1  in  XLEN  dedicated x1 value
bpu2rf_rs1_ena  out  1  one-cycle read request on the shared rs1 port
rf2bpu_rs1  in  XLEN  shared port read data, valid the cycle after the request
flush  in  1  pipeline flush
out_valid  out  1  prediction valid
out_ready  in  1  consumer accepts prediction
prdt_taken  out  1  predicted taken
prdt_op1  out  XLEN  next-PC operand 1
prdt_op2  out  XLEN  next-PC operand 2
prdt_pc  out  XLEN  prdt_op1 + prdt_op2, modulo 2^XLEN

Behaviour:
- States: IDLE, WAIT_DEP, RF_REQ, RF_RSP, OUT.
- in_ready = (state == IDLE). An instruction is accepted when in_valid & in_ready; fields are latched on acceptance.
- On reset, or on flush in any state:
  - state -> IDLE.
  - out_valid, prdt_taken and bpu2rf_rs1_ena = 0.
  - prdt_op1, prdt_op2 and prdt_pc = 0.
  - flush overrides acceptance in the same cycle. Any captured or in-flight RF response is discarded.
- Prediction rules (latched values):
  - Not bjp: taken = 0; op1 = pc; op2 = 4 if rv32, else 2.
  - JAL: taken = 1; op1 = pc; op2 = imm.
  - Bxx: taken = imm[XLEN-1] (backward taken, forward not taken).
    - Taken: op1 = pc, op2 = imm.
    - Not taken: op1 = pc, op2 = 4 if rv32, else 2.
  - JALR: taken = 1; op2 = imm; op1 = base register value:
    - rs1 = x0: op1 = 0.
    - rs1 = x1: op1 = rf_x1.
    - rs1 = other: op1 = captured rf2bpu_rs1.
- Dependency for JALR on rs1 = r (r != 0): dep = ~oitf_empty | (ir_valid & ir_rdwen & ir_rdidx == r). Evaluated every cycle.
- Transitions:
  - IDLE, accept:
    - Non-JALR, or JALR x0: -> OUT. out_valid rises the next cycle (latency 1).
    - JALR x1 or xN: -> WAIT_DEP if dep; otherwise x1 -> OUT (rf_x1 sampled at the transition), xN -> RF_REQ.
  - WAIT_DEP, stays while dep:
    - x1: on ~dep, sample rf_x1, -> OUT.
    - xN: on ~dep, -> RF_REQ.
  - RF_REQ:
    - bpu2rf_rs1_ena = ~ir_rs1en (combinational in this state only). IR has priority on the port.
    - Request issued -> RF_RSP.
    - If dep reasserts before issue -> WAIT_DEP.
  - RF_RSP: capture rf2bpu_rs1 into op1 -> OUT.
  - OUT: out_valid = 1, outputs stable; out_ready -> IDLE.
- No back-to-back acceptance in the OUT exit cycle. The minimum initiation interval is 2 cycles.
- prdt_pc is computed from the registered operands. It wraps on overflow (e.g. 0xFFFFFFFC + 8 = 0x00000004).

Test Plan:
- JAL at pc = 0x80000000, imm = 0x100 -> out_valid 1 cycle after accept; taken = 1; prdt_pc = 0x80000100.
- Bxx at pc = 0x200: imm = 0xFFFFFFF0 -> taken = 1, prdt_pc = 0x1F0. imm = 0x40, rv32 = 0 -> taken = 0, prdt_pc = 0x202.
- JALR x1, imm = 4, oitf_empty = 0 for 3 cycles, rf_x1 = 0x1000 -> held in WAIT_DEP 3 cycles, then prdt_pc = 0x1004.
- JALR x5, imm = 0, ir_rs1en high 2 cycles in RF_REQ, rf2bpu_rs1 = 0x3000 -> ena asserted once on cycle 3; prdt_pc = 0x3000, taken = 1.
- flush asserted in RF_RSP -> next cycle IDLE; out_valid never rises; a new instruction is then accepted normally.
- out_ready held low 4 cycles in OUT -> outputs stable and in_ready = 0 throughout. Wrap case: JALR x1 with rf_x1 = 0xFFFFFFFC, imm = 8 -> prdt_pc = 0x4.
